// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-port SRAM arbiter.
// FSM encoding and default bus widths.
package sram_arb_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/sram_arb_if.sv
// Requester and SRAM-controller bus bundle for the arbiter.
// slave = arbiter view, master = environment view.
interface sram_arb_if
  import sram_arb_pkg::*;
#(
  parameter int AW = DEF_ADDR_W,
  parameter int DW = DEF_DATA_W
);
  logic          rq0_r_en;
  logic          rq0_w_en;
  logic [AW-1:0] rq0_addr;
  logic [DW-1:0] rq0_wdata;
  logic [DW-1:0] rq0_rdata;
  logic          rq0_ack;
  logic          rq0_stall;

  logic          rq1_r_en;
  logic          rq1_w_en;
  logic [AW-1:0] rq1_addr;
  logic [DW-1:0] rq1_wdata;
  logic [DW-1:0] rq1_rdata;
  logic          rq1_ack;
  logic          rq1_stall;

  logic          mem_r_en;
  logic          mem_w_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_not_ready;

  modport slave (
    input  rq0_r_en, rq0_w_en, rq0_addr, rq0_wdata,
    input  rq1_r_en, rq1_w_en, rq1_addr, rq1_wdata,
    input  mem_rdata, mem_not_ready,
    output rq0_rdata, rq0_ack, rq0_stall,
    output rq1_rdata, rq1_ack, rq1_stall,
    output mem_r_en, mem_w_en, mem_addr, mem_wdata
  );

  modport master (
    output rq0_r_en, rq0_w_en, rq0_addr, rq0_wdata,
    output rq1_r_en, rq1_w_en, rq1_addr, rq1_wdata,
    output mem_rdata, mem_not_ready,
    input  rq0_rdata, rq0_ack, rq0_stall,
    input  rq1_rdata, rq1_ack, rq1_stall,
    input  mem_r_en, mem_w_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin picker, one-hot grant.
// On a tie the side that did not win last time is chosen.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       fixed_prio_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    unique case (req_i)
      2'b01: grant_o = 2'b01;
      2'b10: grant_o = 2'b10;
      2'b11: grant_o = (fixed_prio_i | last_i) ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM controller port between two requesters.
// IDLE -> ISSUE -> BUSY -> RESP, with latched address/data per access.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter bit FIXED_PRIO = 1'b0
) (
  input logic      clk,
  input logic      rst,
  sram_arb_if.slave bus
);

  state_e              state_q;
  logic                rr_last_q;
  logic                owner_q;
  logic                op_rd_q;
  logic                busy_first_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                mem_r_en_q;
  logic                mem_w_en_q;
  logic [1:0]          ack_q;
  logic [DATA_W-1:0]   rdata0_q;
  logic [DATA_W-1:0]   rdata1_q;

  logic [1:0]          req;
  logic [1:0]          grant;
  logic                sel_rd;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  assign req = {bus.rq1_r_en | bus.rq1_w_en,
                bus.rq0_r_en | bus.rq0_w_en};

  rr_arb2 u_arb (
    .req_i       (req),
    .last_i      (rr_last_q),
    .fixed_prio_i(FIXED_PRIO),
    .grant_o     (grant)
  );

  // read wins when a requester raises both enables
  assign sel_rd    = grant[1] ? bus.rq1_r_en  : bus.rq0_r_en;
  assign sel_addr  = grant[1] ? bus.rq1_addr  : bus.rq0_addr;
  assign sel_wdata = grant[1] ? bus.rq1_wdata : bus.rq0_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_last_q    <= 1'b1;
      owner_q      <= 1'b0;
      op_rd_q      <= 1'b0;
      busy_first_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_r_en_q   <= 1'b0;
      mem_w_en_q   <= 1'b0;
      ack_q        <= 2'b00;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      ack_q      <= 2'b00;
      unique case (state_q)
        ST_IDLE: begin
          if (!bus.mem_not_ready && (|req)) begin
            owner_q    <= grant[1];
            rr_last_q  <= grant[1];
            op_rd_q    <= sel_rd;
            addr_q     <= sel_addr;
            wdata_q    <= sel_wdata;
            mem_r_en_q <= sel_rd;
            mem_w_en_q <= ~sel_rd;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          busy_first_q <= 1'b1;
          state_q      <= ST_BUSY;
        end
        ST_BUSY: begin
          // controller raises not_ready only after seeing the pulse
          if (busy_first_q) begin
            busy_first_q <= 1'b0;
          end else if (!bus.mem_not_ready) begin
            ack_q[owner_q] <= 1'b1;
            if (op_rd_q && owner_q)  rdata1_q <= bus.mem_rdata;
            if (op_rd_q && !owner_q) rdata0_q <= bus.mem_rdata;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_r_en  = mem_r_en_q;
  assign bus.mem_w_en  = mem_w_en_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rq0_ack   = ack_q[0];
  assign bus.rq1_ack   = ack_q[1];
  assign bus.rq0_rdata = rdata0_q;
  assign bus.rq1_rdata = rdata1_q;
  assign bus.rq0_stall = req[0] & ~ack_q[0];
  assign bus.rq1_stall = req[1] & ~ack_q[1];

endmodule
